// File: rtl/spi_flash_initiator.sv
// SPI flash initiator: runs one CS-framed command (cmd, addr, write payload, read) in SPI mode 0.
// Optional quad-output read (0x6B) is built when SPI_FLASH_INITIATOR_QUAD_READ_EN is defined.
module spi_flash_initiator #(
   parameter int CLK_DIV = 2,
   parameter int CS_IDLE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd,
   input  logic [23:0] addr,
   input  logic        addr_en,
   input  logic [11:0] wr_len,
   input  logic [11:0] rd_len,
   input  logic [7:0]  wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [7:0]  rd_data,
   output logic        rd_strobe,
   output logic        done,
   output logic        busy,
   output logic        spi_clk,
   output logic        spi_cs,
   output logic [3:0]  spi_do,
   output logic [3:0]  spi_do_enable,
   input  logic [3:0]  spi_di
);
   typedef enum logic [3:0] {
      S_IDLE, S_CS_SETUP, S_CMD, S_ADDR, S_WRITE, S_DUMMY, S_READ, S_CS_HOLD, S_CS_WAIT
   } state_t;

   localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
   localparam logic [15:0] IDLE_M1 = 16'(CS_IDLE - 1);

   state_t      state, nxt, n_read, n_dummy, n_write, n_addr;
   logic [15:0] cnt;
   logic [4:0]  bit_cnt, last_bit;
   logic [23:0] sh;
   logic [6:0]  rx;
   logic [7:0]  cmd_q;
   logic [23:0] addr_q;
   logic        addr_en_q, have_byte;
   logic [11:0] wr_left, rd_left;
`ifdef SPI_FLASH_INITIATOR_QUAD_READ_EN
   logic        quad_q;
`else
   logic        unused_di;
   assign unused_di = ^{spi_di[3:2], spi_di[0]};
`endif

   // Phase that follows the current one; empty phases fall through.
   always_comb begin
      n_read  = (rd_left != 12'd0) ? S_READ : S_CS_HOLD;
`ifdef SPI_FLASH_INITIATOR_QUAD_READ_EN
      n_dummy = quad_q ? S_DUMMY : n_read;
`else
      n_dummy = n_read;
`endif
      n_write = (wr_left != 12'd0) ? S_WRITE : n_dummy;
      n_addr  = addr_en_q ? S_ADDR : n_write;
      case (state)
         S_CMD:   nxt = n_addr;
         S_ADDR:  nxt = n_write;
         S_WRITE: nxt = n_dummy;
         S_DUMMY: nxt = n_read;
         default: nxt = S_CS_HOLD;
      endcase
   end

   always_comb begin
      case (state)
         S_ADDR:  last_bit = 5'd23;
`ifdef SPI_FLASH_INITIATOR_QUAD_READ_EN
         S_READ:  last_bit = quad_q ? 5'd1 : 5'd7;
`endif
         default: last_bit = 5'd7;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;   cnt <= '0;        bit_cnt <= '0;   sh <= '0;  rx <= '0;
         cmd_q <= '0;       addr_q <= '0;     addr_en_q <= 1'b0; have_byte <= 1'b0;
         wr_left <= '0;     rd_left <= '0;
`ifdef SPI_FLASH_INITIATOR_QUAD_READ_EN
         quad_q <= 1'b0;
`endif
         cmd_ready <= 1'b1; busy <= 1'b0;     done <= 1'b0;    rd_strobe <= 1'b0;
         wr_ready <= 1'b0;  rd_data <= '0;    spi_cs <= 1'b1;  spi_clk <= 1'b0;
         spi_do <= '0;      spi_do_enable <= '0;
      end else begin
         rd_strobe <= 1'b0;
         done      <= 1'b0;
         case (state)
            S_IDLE: if (cmd_valid) begin
               cmd_q <= cmd; addr_q <= addr; addr_en_q <= addr_en;
               wr_left <= wr_len; rd_left <= rd_len;
`ifdef SPI_FLASH_INITIATOR_QUAD_READ_EN
               quad_q <= (cmd == 8'h6B);
`endif
               cmd_ready <= 1'b0; busy <= 1'b1; spi_cs <= 1'b0;
               cnt <= DIV_M1; state <= S_CS_SETUP;
            end
            S_CS_SETUP: if (cnt == 16'd0) begin
               state <= S_CMD; bit_cnt <= '0; cnt <= DIV_M1;
               sh <= {cmd_q[6:0], 17'h0};
               spi_do <= {3'b000, cmd_q[7]}; spi_do_enable <= 4'b0001;
            end else cnt <= cnt - 16'd1;
            S_CS_HOLD: if (cnt == 16'd0) begin
               spi_cs <= 1'b1; done <= 1'b1; cnt <= IDLE_M1; state <= S_CS_WAIT;
            end else cnt <= cnt - 16'd1;
            S_CS_WAIT: if (cnt == 16'd0) begin
               state <= S_IDLE; cmd_ready <= 1'b1; busy <= 1'b0;
            end else cnt <= cnt - 16'd1;
            default: begin
               // Write stall: SCK parked low until the next payload byte is handed over.
               if (state == S_WRITE && !have_byte) begin
                  if (wr_valid) begin
                     have_byte <= 1'b1; wr_ready <= 1'b0; cnt <= DIV_M1;
                     sh <= {wr_data[6:0], 17'h0};
                     spi_do <= {3'b000, wr_data[7]};
                  end
               end else if (!spi_clk) begin
                  if (cnt != 16'd0) cnt <= cnt - 16'd1;
                  else begin
                     spi_clk <= 1'b1; cnt <= DIV_M1;
                     if (state == S_READ) begin
`ifdef SPI_FLASH_INITIATOR_QUAD_READ_EN
                        if (quad_q) begin
                           rx <= {rx[2:0], spi_di};
                           if (bit_cnt == last_bit) begin
                              rd_data <= {rx[3:0], spi_di}; rd_strobe <= 1'b1;
                           end
                        end else
`endif
                        begin
                           rx <= {rx[5:0], spi_di[1]};
                           if (bit_cnt == last_bit) begin
                              rd_data <= {rx, spi_di[1]}; rd_strobe <= 1'b1;
                           end
                        end
                     end
                  end
               end else if (cnt != 16'd0) cnt <= cnt - 16'd1;
               else begin
                  spi_clk <= 1'b0; cnt <= DIV_M1;
                  if (bit_cnt != last_bit) begin
                     bit_cnt <= bit_cnt + 5'd1;
                     if (state != S_READ && state != S_DUMMY) begin
                        spi_do <= {3'b000, sh[23]}; sh <= {sh[22:0], 1'b0};
                     end
                  end else if (state == S_WRITE && wr_left != 12'd1) begin
                     wr_left <= wr_left - 12'd1; bit_cnt <= '0;
                     have_byte <= 1'b0; wr_ready <= 1'b1;
                  end else if (state == S_READ && rd_left != 12'd1) begin
                     rd_left <= rd_left - 12'd1; bit_cnt <= '0;
                  end else begin
                     state <= nxt; bit_cnt <= '0;
                     spi_do <= '0; spi_do_enable <= '0;
                     case (nxt)
                        S_ADDR: begin
                           sh <= {addr_q[22:0], 1'b0};
                           spi_do <= {3'b000, addr_q[23]}; spi_do_enable <= 4'b0001;
                        end
                        S_WRITE: begin
                           have_byte <= 1'b0; wr_ready <= 1'b1; spi_do_enable <= 4'b0001;
                        end
                        default: ;
                     endcase
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_flash_initiator.sv
// Directed bench for spi_flash_initiator with a behavioural SPI flash and a read-data scoreboard.
module tb_spi_flash_initiator;
   localparam int CS_IDLE = 4;

   logic        clk = 1'b0, reset = 1'b1;
   logic        cmd_valid = 1'b0, addr_en = 1'b0, wr_valid = 1'b0;
   logic [7:0]  cmd = '0, wr_data = '0;
   logic [23:0] addr = '0;
   logic [11:0] wr_len = '0, rd_len = '0;
   logic [3:0]  spi_di = '0;
   logic        cmd_ready, wr_ready, rd_strobe, done, busy, spi_clk, spi_cs;
   logic [7:0]  rd_data;
   logic [3:0]  spi_do, spi_do_enable;

   int vecs = 0, errs = 0;
   int n_strobe = 0, n_done = 0, sck_total = 0;
   logic [31:0] exp_q[$];

   spi_flash_initiator #(.CLK_DIV(2), .CS_IDLE(CS_IDLE)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
      .addr(addr), .addr_en(addr_en), .wr_len(wr_len), .rd_len(rd_len), .wr_data(wr_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_strobe(rd_strobe),
      .done(done), .busy(busy), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_do(spi_do),
      .spi_do_enable(spi_do_enable), .spi_di(spi_di));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- flash model ----------------
   int          m_rises, m_en_bad, m_k;
   logic [31:0] m_hdr;
   logic [7:0]  m_opc, m_wsr, m_b;
   logic [7:0]  m_prog[$];

   function automatic logic [7:0] mem_rd(input logic [23:0] a);
      case (a)
         24'h123456: return 8'hA5;
         24'h123457: return 8'h3C;
         default:    return 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] id_rd(input int i);
      case (i)
         0: return 8'hC2;
         1: return 8'h20;
         2: return 8'h18;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [3:0] nib_rd(input int i);
      case (i)
         0: return 4'h5;
         1: return 4'hA;
         2: return 4'hC;
         3: return 4'h3;
         default: return 4'h0;
      endcase
   endfunction

   always @(negedge spi_cs) begin
      m_rises = 0; m_hdr = '0; m_opc = '0; m_en_bad = 0; spi_di = '0;
      m_prog.delete();
   end

   always @(posedge spi_clk) begin
      sck_total++;
      if (!spi_cs) begin
         if (m_rises < 32) m_hdr = {m_hdr[30:0], spi_do[0]};
         if (m_rises == 7) m_opc = m_hdr[7:0];
         if (m_opc == 8'h02 && m_rises >= 32) begin
            m_wsr = {m_wsr[6:0], spi_do[0]};
            if ((m_rises - 32) % 8 == 7) m_prog.push_back(m_wsr);
         end
         if ((m_opc == 8'h03 || m_opc == 8'h6B) && m_rises >= 32 && spi_do_enable != 4'b0000)
            m_en_bad++;
         m_rises++;
      end
   end

   // Mode 0: flash shifts its next output bit on the falling SCK edge.
   always @(negedge spi_clk) begin
      if (spi_cs === 1'b0) begin
         if (m_opc == 8'h9F && m_rises >= 8) begin
            m_k = m_rises - 8; m_b = id_rd(m_k / 8);
            spi_di = {2'b00, m_b[7 - (m_k % 8)], 1'b0};
         end else if (m_opc == 8'h03 && m_rises >= 32) begin
            m_k = m_rises - 32; m_b = mem_rd(m_hdr[23:0] + 24'(m_k / 8));
            spi_di = {2'b00, m_b[7 - (m_k % 8)], 1'b0};
         end else if (m_opc == 8'h6B && m_rises >= 40) begin
            spi_di = nib_rd(m_rises - 40);
         end
      end
   end

   // ---------------- scoreboard / event monitor ----------------
   always @(negedge clk) begin
      if (rd_strobe === 1'b1) begin
         n_strobe++;
         chk("rd_data", {24'h0, rd_data}, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
      end
      if (done === 1'b1) n_done++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic start(input logic [7:0] c, input logic [23:0] a, input logic ae,
                        input logic [11:0] wl, input logic [11:0] rl);
      int t;
      t = 0;
      while (cmd_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
      chk("cmd_ready_wait", {31'h0, cmd_ready}, 1);
      cmd = c; addr = a; addr_en = ae; wr_len = wl; rd_len = rl; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0; cmd = 8'hFF; addr = 24'hFFFFFF; addr_en = ~ae;
      wr_len = 12'hFFF; rd_len = 12'hFFF;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int t;
      t = 0;
      while (done !== 1'b1 && t < budget) begin @(negedge clk); t++; end
      chk(tag, {31'h0, done}, 1);
   endtask

   // From the done cycle: CS must stay high and cmd_ready return after CS_IDLE cycles.
   task automatic finish_txn(input string tag);
      int k, cs_low;
      k = 0; cs_low = 0;
      while (cmd_ready !== 1'b1 && k < 50) begin
         @(negedge clk); k++;
         if (spi_cs !== 1'b1) cs_low++;
      end
      chk({tag, "_cs_idle_high"}, cs_low, 0);
      chk({tag, "_ready_latency"}, k, CS_IDLE);
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall);
      int t, bad, s0;
      t = 0;
      while (wr_ready !== 1'b1 && t < 500) begin @(negedge clk); t++; end
      chk("wr_ready_wait", {31'h0, wr_ready}, 1);
      if (stall > 0) begin
         bad = 0; s0 = sck_total;
         repeat (stall) begin
            @(negedge clk);
            if (spi_clk !== 1'b0 || spi_cs !== 1'b0 || wr_ready !== 1'b1) bad++;
         end
         chk("stall_sck_low_cs_low", bad, 0);
         chk("stall_no_sck_edges", sck_total - s0, 0);
      end
      wr_data = b; wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0; wr_data = 8'h00;
   endtask

   // ---------------- directed sequence ----------------
   int s0, d0, r0, t;
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_spi_cs", {31'h0, spi_cs}, 1);
      chk("rst_spi_clk", {31'h0, spi_clk}, 0);
      chk("rst_spi_do", {28'h0, spi_do}, 0);
      chk("rst_do_enable", {28'h0, spi_do_enable}, 0);
      chk("rst_cmd_ready", {31'h0, cmd_ready}, 1);
      chk("rst_busy_done_strobe_wrrdy", {28'h0, busy, done, rd_strobe, wr_ready}, 0);
      chk("rst_rd_data", {24'h0, rd_data}, 0);
      reset = 1'b0;
      @(negedge clk);

      // RDID
      exp_q.push_back(32'hC2); exp_q.push_back(32'h20); exp_q.push_back(32'h18);
      s0 = n_strobe; d0 = n_done; r0 = sck_total;
      start(8'h9F, 24'h0, 1'b0, 12'd0, 12'd3);
      chk("rdid_busy", {31'h0, busy}, 1);
      wait_done("rdid_done", 2000);
      finish_txn("rdid");
      chk("rdid_opcode", {24'h0, m_opc}, 32'h9F);
      chk("rdid_sck_rises", sck_total - r0, 32);
      chk("rdid_strobes", n_strobe - s0, 3);
      chk("rdid_done_pulses", n_done - d0, 1);

      // READ 0x03
      exp_q.push_back(32'hA5); exp_q.push_back(32'h3C);
      s0 = n_strobe;
      start(8'h03, 24'h123456, 1'b1, 12'd0, 12'd2);
      wait_done("read_done", 3000);
      finish_txn("read");
      chk("read_mosi_hdr", m_hdr, 32'h03123456);
      chk("read_strobes", n_strobe - s0, 2);
      chk("read_oe_off_in_data", m_en_bad, 0);

      // Page program with a stall before byte 3
      s0 = n_strobe;
      start(8'h02, 24'h000100, 1'b0 | 1'b1, 12'd4, 12'd0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 20);
      send_byte(8'h44, 0);
      wait_done("pp_done", 3000);
      finish_txn("pp");
      chk("pp_hdr", m_hdr, 32'h02000100);
      chk("pp_nbytes", m_prog.size(), 4);
      chk("pp_payload", (m_prog.size() == 4) ? {m_prog[0], m_prog[1], m_prog[2], m_prog[3]} : 32'h0,
          32'h11223344);
      chk("pp_no_strobe", n_strobe - s0, 0);

      // WREN
      r0 = sck_total;
      start(8'h06, 24'h0, 1'b0, 12'd0, 12'd0);
      wait_done("wren_done", 1000);
      finish_txn("wren");
      chk("wren_opcode", {24'h0, m_opc}, 32'h06);
      chk("wren_sck_rises", sck_total - r0, 8);

      // Reset during the second address byte
      s0 = n_strobe;
      start(8'h03, 24'h123456, 1'b1, 12'd0, 12'd2);
      t = 0;
      while (m_rises < 18 && t < 1000) begin @(negedge clk); t++; end
      chk("abort_reached_addr2", (m_rises >= 18 && m_rises < 24) ? 32'd1 : 32'd0, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_spi_cs", {31'h0, spi_cs}, 1);
      chk("abort_spi_clk", {31'h0, spi_clk}, 0);
      chk("abort_do_enable", {28'h0, spi_do_enable}, 0);
      chk("abort_busy", {31'h0, busy}, 0);
      reset = 1'b0;
      r0 = sck_total;
      repeat (5) @(negedge clk);
      chk("abort_no_sck", sck_total - r0, 0);
      chk("abort_no_strobe", n_strobe - s0, 0);

      // RDID after the aborted transfer
      exp_q.push_back(32'hC2); exp_q.push_back(32'h20); exp_q.push_back(32'h18);
      s0 = n_strobe; r0 = sck_total;
      start(8'h9F, 24'h0, 1'b0, 12'd0, 12'd3);
      wait_done("rdid2_done", 2000);
      finish_txn("rdid2");
      chk("rdid2_sck_rises", sck_total - r0, 32);
      chk("rdid2_strobes", n_strobe - s0, 3);

`ifdef SPI_FLASH_INITIATOR_QUAD_READ_EN
      exp_q.push_back(32'h5A); exp_q.push_back(32'hC3);
      s0 = n_strobe; r0 = sck_total;
      start(8'h6B, 24'h000000, 1'b1, 12'd0, 12'd2);
      wait_done("quad_done", 3000);
      finish_txn("quad");
      chk("quad_sck_rises", sck_total - r0, 44);
      chk("quad_oe_off", m_en_bad, 0);
      chk("quad_strobes", n_strobe - s0, 2);
`endif

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/spi_flash_initiator.md
Name: spi_flash_initiator

Overview:
- SPI controller-side engine that drives a real SPI flash (or PSRAM) chip from the `clk` domain.
- The control CPU queues one command descriptor: opcode, optional 24-bit address, optional write payload, optional read length. The block then generates CS/SCK/data waveforms and streams bytes back.
- It is the initiating end of the same command set the spispy target answers (0x9F, 0x05, 0x06, 0x04, 0x03, 0x02, 0x20). It is used to read, erase and program the physical flash behind the emulator.

Parameters:
- CLK_DIV, 2, SCK half-period in `clk` cycles; legal range 1..255.
- CS_IDLE, 4, minimum `clk` cycles CS stays high between transactions.

Ports:
- clk  input  1  system clock; all logic in this domain.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  descriptor present.
- cmd_ready  output  1  high only in IDLE; a transfer starts on cmd_valid && cmd_ready.
- cmd  input  8  opcode.
- addr  input  24  address, sent MSB first.
- addr_en  input  1  send the 3 address bytes.
- wr_len  input  12  payload bytes to send after cmd/addr (0 = none).
- rd_len  input  12  bytes to read after the write phase (0 = none).
- wr_data  input  8  payload byte.
- wr_valid  input  1  wr_data valid.
- wr_ready  output  1  byte consumed when wr_valid && wr_ready.
- rd_data  output  8  received byte.
- rd_strobe  output  1  one-cycle pulse per received byte.
- done  output  1  one-cycle pulse when CS returns high at end of transfer.
- busy  output  1  high from accept until the end of CS idle.
- spi_clk  output  1  SCK, mode 0 (idles low).
- spi_cs  output  1  chip select, active low.
- spi_do  output  4  data out; bit0 = IO0/MOSI.
- spi_do_enable  output  4  per-pin output enable.
- spi_di  input  4  data in; bit1 = IO1/MISO.

Behaviour:
- Reset values: spi_cs=1, spi_clk=0, spi_do=0, spi_do_enable=0, cmd_ready=1, busy=0, done=0, rd_strobe=0, wr_ready=0, rd_data=0.
- Reset mid-transfer: the same values apply on the next edge, with no further SCK edges.
- Descriptor fields are latched at accept. Input changes after accept are ignored.
- States:
  - IDLE
  - CS_SETUP: CS low for CLK_DIV cycles.
  - CMD: 8 bits.
  - ADDR: 24 bits, only if addr_en.
  - WRITE: wr_len bytes.
  - READ: rd_len bytes.
  - CS_HOLD: CLK_DIV cycles with SCK low.
  - CS_WAIT: CS high for CS_IDLE cycles, then IDLE.
- Empty phases are skipped.
- Bit timing:
  - Each bit = SCK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - spi_do changes only while SCK is low.
  - spi_di[1] is sampled on the clk cycle in which SCK is driven high.
  - MSB first.
- spi_do_enable:
  - 4'b0001 during CMD, ADDR and WRITE.
  - 4'b0000 during READ and all other states.
- Write handshake:
  - wr_ready is asserted during the low half preceding each payload byte's first bit.
  - If wr_valid is low, SCK stays low and CS stays low (stall) until the byte arrives.
  - No bit of the byte is shifted out before the handshake.
- Read timing: rd_strobe pulses exactly one cycle after the 8th bit of each byte is sampled, with rd_data stable until the next strobe.
- Counters: byte counters are 12 bits. wr_len/rd_len = 4095 are legal maximums; there is no wrap.
- done pulses on the cycle CS_HOLD → CS_WAIT, coincident with spi_cs rising.
- A cmd_valid held high during busy is not accepted until IDLE. Back-to-back transfers are therefore separated by ≥ CS_IDLE cycles of CS high.

Optional Feature:
- Macro: SPI_FLASH_INITIATOR_QUAD_READ_EN.
- When defined:
  - Opcode 0x6B (quad output fast read) runs its READ phase 4 bits per SCK, nibble high first, sampling spi_di[3:0]. Each byte takes 2 SCK periods.
  - 8 dummy SCK cycles with spi_do_enable=0 are inserted between ADDR and READ.
  - The CMD and ADDR phases stay single-bit.
- When undefined: 0x6B is treated as any other opcode (single-bit, no dummy cycles). No quad datapath logic is synthesized.

Test Plan:
- RDID, CLK_DIV=2: cmd=0x9F, addr_en=0, rd_len=3; flash model returns C2 20 18 → exactly 3 rd_strobe pulses with C2, 20, 18; 32 SCK rising edges total; one done pulse; spi_cs high ≥4 cycles afterwards.
- READ: cmd=0x03, addr=0x123456, addr_en=1, rd_len=2; model memory[0x123456..7]=A5,3C → MOSI carries 03 12 34 56; rd_data A5 then 3C; spi_do_enable=0 during the data bytes.
- Page program with stall: cmd=0x02, addr=0x000100, wr_len=4, data 11 22 33 44, wr_valid dropped for 20 cycles before byte 3 → SCK held low with CS low during the stall; model receives 11 22 33 44 intact; no rd_strobe.
- WREN: cmd=0x06, no addr, wr_len=0, rd_len=0 → exactly 8 SCK edges on 0x06; done; cmd_ready back after CS_IDLE cycles.
- Reset during ADDR byte 2 → next cycle spi_cs=1, spi_clk=0, spi_do_enable=0, busy=0; a following RDID completes correctly.
- Quad read (macro on): cmd=0x6B, addr=0x000000, rd_len=2, model drives nibbles 5,A,C,3 → rd_data 5A, C3; 8 dummy SCK cycles with outputs disabled; 4 SCK periods in the data phase.
